// File: rtl/iob_uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmit path among N_REQ byte streams.
// Optional stall-timeout release is compiled in with `define IOB_UART_ARB_TIMEOUT_EN.
module iob_uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      en_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  input  logic [N_REQ-1:0]          req_last_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic                      tx_ready_i,
  output logic                      tx_wen_o,
  output logic [DATA_W-1:0]         tx_data_o,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOCK = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    ptr, gidx, pick, gnext;
  logic [N_REQ-1:0] one_hot;
  logic             found, last_q, wait_q, owner_valid, accept;

  // Circular search for the first valid requester at or above the pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid_i[(int'(ptr) + i) % N_REQ]) begin
        found = 1'b1;
        pick  = IW'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    one_hot       = '0;
    one_hot[pick] = 1'b1;
  end

  assign gnext       = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
  assign owner_valid = req_valid_i[gidx];
  assign accept      = (state == S_LOCK) && owner_valid && tx_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (state == S_LOCK) req_ready_o[gidx] = tx_ready_i;
  end

`ifdef IOB_UART_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt;
  logic                 timeout_q;
  assign timeout_o = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_W, TIMEOUT_CYC};
  assign timeout_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gidx      <= '0;
      grant_o   <= '0;
      busy_o    <= 1'b0;
      tx_wen_o  <= 1'b0;
      tx_data_o <= '0;
      last_q    <= 1'b0;
      wait_q    <= 1'b0;
`ifdef IOB_UART_ARB_TIMEOUT_EN
      tcnt      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      tx_wen_o <= 1'b0;
`ifdef IOB_UART_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        S_IDLE: if (en_i && found) begin
          gidx    <= pick;
          grant_o <= one_hot;
          busy_o  <= 1'b1;
          state   <= S_LOCK;
`ifdef IOB_UART_ARB_TIMEOUT_EN
          tcnt    <= '0;
`endif
        end
        S_LOCK: begin
          if (accept) begin
            tx_wen_o  <= 1'b1;
            tx_data_o <= req_data_i[gidx*DATA_W +: DATA_W];
            last_q    <= req_last_i[gidx];
            wait_q    <= 1'b0;
            state     <= S_WAIT;
`ifdef IOB_UART_ARB_TIMEOUT_EN
            tcnt      <= '0;
          end else if (!owner_valid) begin
            // Owner has gone silent; release once the stall budget is spent.
            if (tcnt == TIMEOUT_W'(TIMEOUT_CYC - 1)) begin
              ptr       <= gnext;
              grant_o   <= '0;
              busy_o    <= 1'b0;
              timeout_q <= 1'b1;
              state     <= S_IDLE;
            end else begin
              tcnt <= tcnt + TIMEOUT_W'(1);
            end
`endif
          end
        end
        // Two cycles: strobe cycle plus one to mask a stale tx_ready_i.
        S_WAIT: begin
          if (!wait_q) begin
            wait_q <= 1'b1;
          end else if (last_q) begin
            ptr     <= gnext;
            grant_o <= '0;
            busy_o  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            state <= S_LOCK;
`ifdef IOB_UART_ARB_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
